bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
Round-robin bus arbiter that shares the single downstream transfer path between N packer-style requesters, such as byte-to-64-bit collectors. Each requester raises req, waits for gnt, holds req for the length of its transfer, then drops req. The arbiter drives each requester's gnt input and reports the current owner to the bus mux. A hold-time watchdog withdraws a grant that is held too long.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_HOLD, 16, maximum consecutive grant cycles before forced release (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request, level; held high for the whole transfer
gnt  out  N_REQ  one-hot-or-zero grant, registered
owner  out  $clog2(N_REQ)  index of granted requester; valid while busy
busy  out  1  high while any gnt bit is high
timeout  out  1  one-cycle pulse when a grant is force-released by the watchdog

Behaviour:
- Reset (rst low, async): gnt=0, owner=0, busy=0, timeout=0, state=IDLE, hold_cnt=0. Round-robin pointer is set so requester 0 has highest priority on the first grant.
- All outputs are registered. A req first seen high at edge k produces gnt at edge k (visible in the cycle after k). Minimum latency from req assertion to gnt visible is 1 cycle.
- State IDLE:
  - If any req is high, pick the winner, set the gnt bit, owner and busy, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT, owner's req low (normal release):
  - Clear gnt and busy, go to TURN.
  - Advance the pointer so owner+1 (mod N_REQ) has highest priority.
- State GRANT, owner's req still high:
  - hold_cnt increments each cycle.
  - When hold_cnt == MAX_HOLD-1: clear gnt and busy, pulse timeout for one cycle, advance the pointer as for a normal release, go to TURN.
- State TURN: exactly one dead cycle with gnt=0, so there is no bus overlap, then go to IDLE.
- Back-to-back grants are therefore separated by at least 2 cycles with gnt=0 (TURN, then IDLE's decision edge). Never grant in the same cycle as a release.
- Winner selection: first set bit of req scanning upward from pointer, wrapping modulo N_REQ.
- Requests other than the owner's that change while in GRANT are ignored. Only req[owner] is sampled in GRANT.
- A requester that keeps req high after a timeout loses priority by rotation. It may be re-granted only after all other pending requesters.
- All requests dropping simultaneously in GRANT is handled as a normal release.
- owner holds its last value when busy=0.
- gnt must never have more than one bit set (invariant).

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t
  - localparam for the owner width
  - A function that converts an index to a one-hot vector.
- One sub-module: rr_pick. It is purely combinational: given req, pointer and N_REQ, it returns found and a winner index via rotate-then-find-first-set. It is reused by any future arbiters.
- The FSM, hold counter and pointer register live in bus_rr_arbiter.

Test Plan:
1. Reset, then req=4'b0001 held 5 cycles, then dropped:
   - gnt=4'b0001 one cycle after req, busy=1, owner=0 for 5 cycles.
   - Then gnt=0 for TURN; timeout stays 0.
2. req=4'b1111 held, each requester dropping req 3 cycles after its own grant:
   - Grant order is 0,1,2,3,0.
   - Exactly 2 gnt=0 cycles between consecutive grants.
3. Pointer at 2 (after owner 1 released), req=4'b0011:
   - Scan wraps 2→3→0, so requester 0 wins, then requester 1.
4. MAX_HOLD=16, req[2] held continuously, with req[0] also high:
   - gnt[2] drops after 16 cycles and timeout pulses once.
   - Requester 0 is granted next, before requester 2 is re-granted.
5. rst driven low mid-GRANT, asynchronously and between clock edges:
   - gnt, busy and timeout go to 0 immediately.
   - After release, req=4'b1000 gives a grant to 3.
   - Requester 0 is first priority again when 0 and 3 request together.
6. Random req toggling for 10k cycles with an assertion monitor:
   - gnt is at most one-hot.
   - busy == |gnt.
   - A release is always followed by a gnt=0 cycle.
   - No requester starves beyond (N_REQ-1)*(MAX_HOLD+2) cycles.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus round-robin arbiter family.
// Holds the FSM state encoding, owner-width sizing and one-hot conversion.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int MAX_REQ      = 16;
   localparam int ONEHOT_IDX_W = 4;
   localparam int DEF_N_REQ    = 4;
   localparam int OWNER_W      = $clog2(DEF_N_REQ);

   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [ONEHOT_IDX_W-1:0] idx);
      logic [MAX_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master modport is the arbiter side; the slave modport is the requester side.
interface bus_rr_arbiter_if
   import bus_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int OWNER_W = owner_width(N_REQ)
) ();

   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   gnt;
   logic [OWNER_W-1:0] owner;
   logic               busy;
   logic               timeout;

   modport master (
      input  req,
      output gnt,
      output owner,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      input  gnt,
      input  owner,
      input  busy,
      input  timeout
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner picker: rotate the request vector so the
// pointer sits at bit 0, find the first set bit, then map back to an index.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int OW    = owner_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OW-1:0]    ptr,
   output logic             found,
   output logic [OW-1:0]    winner
);

   logic [N_REQ-1:0] rot_s;
   logic [OW-1:0]    off_s;
   logic             hit_s;
   logic [OW:0]      sum_s;

   // Rotate, find-first-set, then add the offset back modulo N_REQ.
   always_comb begin
      rot_s = N_REQ'({req, req} >> ptr);
      off_s = '0;
      hit_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         off_s = (!hit_s && rot_s[i]) ? OW'(i) : off_s;
         hit_s = hit_s | rot_s[i];
      end
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= (OW+1)'(N_REQ)) begin
         winner = OW'(sum_s - (OW+1)'(N_REQ));
      end else begin
         winner = OW'(sum_s);
      end
      found = hit_s;
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream path between N_REQ requesters,
// with a mandatory dead cycle between owners and a hold-time watchdog.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 16
) (
   input logic              clk,
   input logic              rst,
   bus_rr_arbiter_if.master bus
);

   localparam int OW = owner_width(N_REQ);
   localparam int HW = $clog2(MAX_HOLD);

   arb_state_t       state_r;
   logic [N_REQ-1:0] gnt_r;
   logic [OW-1:0]    owner_r;
   logic             busy_r;
   logic             timeout_r;
   logic [HW-1:0]    hold_cnt_r;
   logic [OW-1:0]    ptr_r;

   logic             found_s;
   logic [OW-1:0]    winner_s;
   logic [N_REQ-1:0] win_oh_s;
   logic             owner_req_s;
   logic             hold_done_s;
   logic [OW-1:0]    nxt_ptr_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .OW    (OW)
   ) u_pick (
      .req    (bus.req),
      .ptr    (ptr_r),
      .found  (found_s),
      .winner (winner_s)
   );

   // Winner one-hot, owner request sample, watchdog limit and post-release pointer.
   always_comb begin
      win_oh_s    = N_REQ'(idx_to_onehot(ONEHOT_IDX_W'(winner_s)));
      owner_req_s = bus.req[owner_r];
      hold_done_s = (hold_cnt_r == HW'(MAX_HOLD - 1));
      if (owner_r == OW'(N_REQ - 1)) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = owner_r + OW'(1);
      end
   end

   // Arbitration FSM with registered grant, owner, busy and timeout outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         gnt_r      <= '0;
         owner_r    <= '0;
         busy_r     <= 1'b0;
         timeout_r  <= 1'b0;
         hold_cnt_r <= '0;
         ptr_r      <= '0;
      end else begin
         timeout_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  gnt_r      <= win_oh_s;
                  owner_r    <= winner_s;
                  busy_r     <= 1'b1;
                  hold_cnt_r <= '0;
                  state_r    <= GRANT;
               end else begin
                  state_r <= IDLE;
               end
            end
            GRANT: begin
               if (!owner_req_s) begin
                  gnt_r      <= '0;
                  busy_r     <= 1'b0;
                  hold_cnt_r <= '0;
                  ptr_r      <= nxt_ptr_s;
                  state_r    <= TURN;
               end else if (hold_done_s) begin
                  // Forced release rotates priority exactly like a normal one.
                  gnt_r      <= '0;
                  busy_r     <= 1'b0;
                  timeout_r  <= 1'b1;
                  hold_cnt_r <= '0;
                  ptr_r      <= nxt_ptr_s;
                  state_r    <= TURN;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HW'(1);
                  state_r    <= GRANT;
               end
            end
            TURN: begin
               state_r <= IDLE;
            end
            default: begin
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.owner   = owner_r;
   assign bus.busy    = busy_r;
   assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed and randomized self-checking bench for bus_rr_arbiter (N_REQ=4, MAX_HOLD=16).
module tb_bus_rr_arbiter;

   localparam int N      = 4;
   localparam int MH     = 16;
   // Two extra cycles cover the TURN/IDLE cycles that can precede the first decision seeing a new request.
   localparam int STARVE = (N - 1) * (MH + 2) + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   gap;
   int   order [5] = '{0, 1, 2, 3, 0};
   int   wait_cnt [N];
   int   hold_left [N];
   logic [N-1:0] prev_gnt;
   logic [N-1:0] r;
   logic         rel_pend;

   bus_rr_arbiter_if #(.N_REQ(N)) bus ();

   bus_rr_arbiter #(
      .N_REQ    (N),
      .MAX_HOLD (MH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out4(input string tag, input logic [3:0] g, input logic b,
                       input logic [1:0] o, input logic t);
      chk({tag, ".gnt"},     32'(bus.gnt),     32'(g));
      chk({tag, ".busy"},    32'(bus.busy),    32'(b));
      chk({tag, ".owner"},   32'(bus.owner),   32'(o));
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      rst     = 1'b0;
      repeat (2) @(negedge clk);
      out4("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      rst = 1'b1;
   endtask

   // Returns the number of gnt=0 samples before a grant appears (20 means none came).
   task automatic wait_grant(output int g);
      g = 0;
      @(negedge clk);
      while (bus.gnt == 4'b0000 && g < 20) begin
         g++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached checks=%0d", checks);
      $fatal(1, "time limit");
   end

   initial begin
      // Test 1: single requester, five-cycle transfer.
      do_reset();
      bus.req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out4("t1.hold", 4'b0001, 1'b1, 2'd0, 1'b0);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      out4("t1.rel", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      out4("t1.idle", 4'b0000, 1'b0, 2'd0, 1'b0);

      // Test 2: all four requesting, rotation 0,1,2,3,0 with two dead cycles.
      do_reset();
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            wait_grant(gap);
            chk("t2.gap0", 32'(gap), 32'd0);
         end else begin
            bus.req[order[k-1]] = 1'b0;
            @(negedge clk);
            chk("t2.rel", 32'(bus.gnt), 32'd0);
            bus.req = 4'b1111;
            wait_grant(gap);
            chk("t2.gap", 32'(gap + 1), 32'd2);
         end
         chk("t2.gnt", 32'(bus.gnt), 32'd1 << order[k]);
         chk("t2.owner", 32'(bus.owner), 32'(order[k]));
         if (k < 4) begin
            repeat (2) begin
               @(negedge clk);
               chk("t2.hold", 32'(bus.gnt), 32'd1 << order[k]);
            end
         end
      end

      // Test 3: pointer at 2, req 0011 wraps to 0 then 1.
      do_reset();
      bus.req = 4'b0010;
      @(negedge clk);
      out4("t3.g1", 4'b0010, 1'b1, 2'd1, 1'b0);
      bus.req = 4'b0000;
      @(negedge clk);
      out4("t3.rel1", 4'b0000, 1'b0, 2'd1, 1'b0);
      bus.req = 4'b0011;
      wait_grant(gap);
      chk("t3.gap0", 32'(gap), 32'd1);
      out4("t3.g0", 4'b0001, 1'b1, 2'd0, 1'b0);
      bus.req = 4'b0010;
      @(negedge clk);
      chk("t3.rel0", 32'(bus.gnt), 32'd0);
      wait_grant(gap);
      chk("t3.gap1", 32'(gap), 32'd1);
      out4("t3.g1b", 4'b0010, 1'b1, 2'd1, 1'b0);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("t3.rel1b", 32'(bus.gnt), 32'd0);

      // Test 4: requester 2 held past MAX_HOLD with requester 0 pending.
      bus.req = 4'b0101;
      wait_grant(gap);
      chk("t4.gap", 32'(gap), 32'd1);
      out4("t4.g2", 4'b0100, 1'b1, 2'd2, 1'b0);
      for (int i = 1; i < MH; i++) begin
         @(negedge clk);
         out4("t4.hold", 4'b0100, 1'b1, 2'd2, 1'b0);
      end
      @(negedge clk);
      out4("t4.to", 4'b0000, 1'b0, 2'd2, 1'b1);
      @(negedge clk);
      out4("t4.dead", 4'b0000, 1'b0, 2'd2, 1'b0);
      @(negedge clk);
      out4("t4.g0", 4'b0001, 1'b1, 2'd0, 1'b0);
      bus.req = 4'b0100;
      @(negedge clk);
      chk("t4.rel0", 32'(bus.gnt), 32'd0);
      wait_grant(gap);
      chk("t4.gap2", 32'(gap), 32'd1);
      out4("t4.g2b", 4'b0100, 1'b1, 2'd2, 1'b0);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("t4.rel2", 32'(bus.gnt), 32'd0);

      // Test 5: asynchronous reset mid-grant restores pointer to 0.
      bus.req = 4'b0010;
      wait_grant(gap);
      chk("t5.gap", 32'(gap), 32'd1);
      out4("t5.g1", 4'b0010, 1'b1, 2'd1, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      out4("t5.async", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst     = 1'b1;
      bus.req = 4'b1001;
      @(negedge clk);
      out4("t5.g0", 4'b0001, 1'b1, 2'd0, 1'b0);
      bus.req = 4'b1000;
      @(negedge clk);
      chk("t5.rel0", 32'(bus.gnt), 32'd0);
      wait_grant(gap);
      chk("t5.gap3", 32'(gap), 32'd1);
      out4("t5.g3", 4'b1000, 1'b1, 2'd3, 1'b0);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("t5.rel3", 32'(bus.gnt), 32'd0);

      // Test 6: protocol-respecting random requesters with invariant monitor.
      prev_gnt = bus.gnt;
      rel_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
         wait_cnt[i]  = 0;
         hold_left[i] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         chk("t6.onehot", 32'($onehot0(bus.gnt)), 32'd1);
         chk("t6.busy", 32'(bus.busy), 32'(|bus.gnt));
         if (rel_pend) chk("t6.dead", 32'(bus.gnt), 32'd0);
         if (prev_gnt != 4'b0000 && bus.gnt != 4'b0000) chk("t6.switch", 32'(bus.gnt), 32'(prev_gnt));
         rel_pend = (prev_gnt != 4'b0000) && (bus.gnt == 4'b0000);
         r = bus.req;
         for (int i = 0; i < N; i++) begin
            if (r[i] && !bus.gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            chk("t6.starve", 32'(wait_cnt[i] <= STARVE), 32'd1);
            if (r[i]) begin
               if (bus.gnt[i]) begin
                  if (hold_left[i] <= 1) r[i] = 1'b0;
                  else hold_left[i]--;
               end else if (prev_gnt[i]) begin
                  r[i] = 1'b0;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               r[i]         = 1'b1;
               hold_left[i] = $urandom_range(1, 20);
            end
         end
         prev_gnt = bus.gnt;
         bus.req  = r;
      end
      bus.req = 4'b0000;
      repeat (4) @(negedge clk);
      chk("t6.end", 32'(bus.gnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
